// File: rtl/integration_mult_pkg.sv
// Shared constants and types for the integration_mult single-precision multiplier.
// Holds the IEEE-754 field widths, special encodings and the Booth core state encoding.
package integration_mult_pkg;

    localparam int EXP_W       = 8;
    localparam int FRAC_W      = 23;
    localparam int SIG_W       = 24;
    localparam int BOOTH_W     = SIG_W + 1;
    localparam int BOOTH_ITERS = BOOTH_W;
    localparam int BIAS        = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_PACK
    } core_state_t;

endpackage

// File: rtl/integration_mult_booth_seq_mult.sv
// 25x25 sequential radix-2 Booth multiplier: loads on start, runs 25 add/shift steps,
// then presents {acc, q} with done high for one cycle. A new start aborts and reloads.
module booth_seq_mult
    import integration_mult_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BOOTH_W-1:0] multiplicand,
    input  logic [BOOTH_W-1:0] multiplier,
    output logic [49:0]        product,
    output logic               done
);

    core_state_t        r_state;
    core_state_t        w_state_next;
    logic [BOOTH_W-1:0] r_m;
    logic [BOOTH_W-1:0] r_acc;
    logic [BOOTH_W-1:0] r_q;
    logic               r_q_1;
    logic [4:0]         r_count;
    logic [BOOTH_W-1:0] w_sum;
    logic               w_step;

    assign w_step = (r_state == ST_LOAD) || (r_state == ST_ITER);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = ST_IDLE;
            ST_LOAD,
            ST_ITER: w_state_next = (r_count == 5'(BOOTH_ITERS - 1)) ? ST_PACK : ST_ITER;
            ST_PACK: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (start) w_state_next = ST_LOAD;
    end

    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_q_1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q_1   <= 1'b0;
            r_count <= '0;
        end else if (start) begin
            r_m     <= multiplicand;
            r_acc   <= '0;
            r_q     <= multiplier;
            r_q_1   <= 1'b0;
            r_count <= '0;
        end else if (w_step) begin
            // Arithmetic right shift of {acc, q, q-1} after the Booth add/subtract.
            {r_acc, r_q, r_q_1} <= {w_sum[BOOTH_W-1], w_sum, r_q};
            r_count             <= r_count + 5'd1;
        end
    end

    assign product = {r_acc, r_q};
    assign done    = (r_state == ST_PACK);

endmodule

// File: rtl/integration_mult.sv
// Registered IEEE-754 single multiplier: operand registers, change-triggered Booth core,
// special-case/exponent/normalize logic and output registers holding the last product.
module integration_mult
    import integration_mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] floatingPointResult,
    output logic        overflowFloatingPoint,
    output logic        exceptionFloatingPoint
);

    logic [31:0]       r_a, r_b;
    logic [31:0]       r_last_a, r_last_b;
    logic              w_start;
    logic              w_done;
    logic [49:0]       w_product;
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic              w_sign;
    logic signed [9:0] w_exp_raw, w_exp_norm;
    logic [FRAC_W-1:0] w_frac;
    logic [31:0]       w_result;
    logic              w_ovf, w_exc;
    logic              w_unused;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_last_a <= '0;
            r_last_b <= '0;
        end else begin
            if (en) begin
                r_a <= a;
                r_b <= b;
            end
            if (w_start) begin
                r_last_a <= r_a;
                r_last_b <= r_b;
            end
        end
    end

    assign w_start = (r_a != r_last_a) || (r_b != r_last_b);

    booth_seq_mult u_core (
        .clk          (clk),
        .reset        (reset),
        .start        (w_start),
        .multiplicand ({2'b01, r_a[FRAC_W-1:0]}),
        .multiplier   ({2'b01, r_b[FRAC_W-1:0]}),
        .product      (w_product),
        .done         (w_done)
    );

    assign w_ea      = r_last_a[30:23];
    assign w_eb      = r_last_b[30:23];
    assign w_sign    = r_last_a[31] ^ r_last_b[31];
    assign w_exp_raw = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
    assign w_unused  = ^{w_product[49:48], r_last_a[FRAC_W-1:0], r_last_b[FRAC_W-1:0]};

    always_comb begin
        w_exp_norm = w_exp_raw;
        w_frac     = w_product[45:23];
        if (w_product[47]) begin
            w_exp_norm = w_exp_raw + 10'sd1;
            w_frac     = w_product[46:24];
        end

        w_result = '0;
        w_ovf    = 1'b0;
        w_exc    = 1'b0;
        if (w_ea == 8'hFF || w_eb == 8'hFF) begin
            w_result = QNAN;
            w_exc    = 1'b1;
        end else if (w_ea == '0 || w_eb == '0) begin
            w_result = '0;
        end else if (w_exp_norm >= 10'sd255) begin
            w_result = {w_sign, POS_INF[30:0]};
            w_ovf    = 1'b1;
        end else if (w_exp_norm <= 10'sd0) begin
            w_result = '0;
        end else begin
            w_result = {w_sign, w_exp_norm[7:0], w_frac};
        end
    end

    // A restart landing on the pack cycle belongs to newer operands, so the stale product is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            floatingPointResult    <= '0;
            overflowFloatingPoint  <= 1'b0;
            exceptionFloatingPoint <= 1'b0;
        end else if (w_done && !w_start) begin
            floatingPointResult    <= w_result;
            overflowFloatingPoint  <= w_ovf;
            exceptionFloatingPoint <= w_exc;
        end
    end

endmodule

// File: tb/tb_integration_mult.sv
// Directed self-checking bench for integration_mult: latency, special cases,
// abort/restart on operand change, enable hold and asynchronous reset mid-run.
module tb_integration_mult;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] floatingPointResult;
    logic        overflowFloatingPoint;
    logic        exceptionFloatingPoint;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_res = '0;

    integration_mult dut (
        .clk                    (clk),
        .reset                  (reset),
        .en                     (en),
        .a                      (a),
        .b                      (b),
        .floatingPointResult    (floatingPointResult),
        .overflowFloatingPoint  (overflowFloatingPoint),
        .exceptionFloatingPoint (exceptionFloatingPoint)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Capture at E0, expect the old result still at E26 and the new one at E27.
    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] exp_r, input logic exp_o, input logic exp_e);
        a = va; b = vb; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        check({tag, " hold"}, floatingPointResult, prev_res);
        @(posedge clk); #1;
        check(tag, floatingPointResult, exp_r);
        check({tag, " ovf"}, {31'b0, overflowFloatingPoint}, {31'b0, exp_o});
        check({tag, " exc"}, {31'b0, exceptionFloatingPoint}, {31'b0, exp_e});
        prev_res = exp_r;
    endtask

    initial begin
        #12;
        check("reset result", floatingPointResult, 32'h0);
        check("reset ovf", {31'b0, overflowFloatingPoint}, 32'h0);
        check("reset exc", {31'b0, exceptionFloatingPoint}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_vec("basic",     32'h4907_2340, 32'h4452_0000, 32'h4DDD_B5D5, 1'b0, 1'b0);
        run_vec("trunc",     32'h4EA0_C8E4, 32'h4EA0_C246, 32'h5DC9_EF25, 1'b0, 1'b0);
        run_vec("negneg",    32'hC381_8000, 32'hC381_8000, 32'h4783_0480, 1'b0, 1'b0);
        run_vec("zero",      32'hCE8E_F06B, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_vec("one",       32'h3F80_0000, 32'h4EA0_C8E4, 32'h4EA0_C8E4, 1'b0, 1'b0);
        run_vec("overflow",  32'h7F00_0000, 32'hC000_0000, 32'hFF80_0000, 1'b1, 1'b0);
        run_vec("inf",       32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b1);
        run_vec("underflow", 32'h0080_0000, 32'h35D0_0998, 32'h0000_0000, 1'b0, 1'b0);

        // Abort: new operands captured 10 edges after the first pair.
        a = 32'h4907_2340; b = 32'h4452_0000; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'h3F80_0000; b = 32'h4EA0_C8E4; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("abort old dropped", floatingPointResult, prev_res);
        repeat (9) @(posedge clk);
        #1;
        check("abort new hold", floatingPointResult, prev_res);
        @(posedge clk); #1;
        check("abort new", floatingPointResult, 32'h4EA0_C8E4);
        prev_res = 32'h4EA0_C8E4;

        // Input changes with en low must not start anything.
        a = 32'h4000_0000; b = 32'h4000_0000; en = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("en low hold", floatingPointResult, prev_res);

        // Asynchronous reset in the middle of a computation.
        a = 32'h4907_2340; b = 32'h4452_0000; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset result", floatingPointResult, 32'h0);
        check("midreset ovf", {31'b0, overflowFloatingPoint}, 32'h0);
        #3;
        reset = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        check("post reset idle", floatingPointResult, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
